// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the multi-channel clock divider.
//   DEF_CW       default divisor/counter width
//   chan_state_e per-channel run state
//   div_clamp()  maps divisors 0 and 1 to 2 (smallest usable period)
//   half_cnt()   number of high cycles in a period, floor(D/2)
package clk_div_pkg;

    localparam int unsigned DEF_CW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } chan_state_e;

    // Operates on 32-bit values so any channel width can use it; callers truncate.
    function automatic logic [31:0] div_clamp(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    function automatic logic [31:0] half_cnt(input logic [31:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable divider channel.
//   Divides clk by the active divisor; divisor updates and start/stop only
//   take effect at period boundaries so the output never produces runt pulses.
// Build option: define DUTY50_EN to add a negedge stage that gives odd
//   divisors a 50% duty cycle; without it odd divisors are low-biased.
// Ports:
//   clk          source clock
//   w_rst        asynchronous active-high reset
//   en_i         run request (level)
//   div_val_i    new divisor, captured on div_load_i (0/1 clamp to 2)
//   div_load_i   one-cycle load strobe
//   load_ack_o   one-cycle pulse when the pending divisor becomes active
//   clk_out_o    divided clock
//   tick_o       one-cycle pulse at the start of each output period
//   run_o        channel is producing periods
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic          clk,
    input  logic          w_rst,
    input  logic          en_i,
    input  logic [CW-1:0] div_val_i,
    input  logic          div_load_i,
    output logic          load_ack_o,
    output logic          clk_out_o,
    output logic          tick_o,
    output logic          run_o
);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] d_act_q, d_act_d;
    logic [CW-1:0] d_pend_q, d_pend_d;
    logic          pend_q, pend_d;
    logic          out_q, out_d;
    logic          tick_q, tick_d;
    logic          ack_q, ack_d;

    logic [CW-1:0] half;
    logic          wrap;
    logic          apply;

    always_comb begin
        half  = CW'(half_cnt(32'(d_act_q)));
        wrap  = (state_q != StIdle) && (cnt_q == d_act_q - CW'(1));
        // A pending divisor is taken at a period boundary, or at once when idle.
        apply = pend_q && ((state_q == StIdle) || wrap);

        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = 1'b0;
        tick_d   = 1'b0;
        ack_d    = apply;
        d_act_d  = apply ? d_pend_q : d_act_q;
        d_pend_d = d_pend_q;
        pend_d   = pend_q & ~apply;

        // A strobe coinciding with an apply becomes the next pending value.
        if (div_load_i) begin
            d_pend_d = CW'(div_clamp(32'(div_val_i)));
            pend_d   = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun, StStopping: begin
                cnt_d  = wrap ? '0 : cnt_q + CW'(1);
                out_d  = (cnt_q < half);
                tick_d = (cnt_q == '0);
                if (wrap) begin
                    if (en_i) begin
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                        out_d   = 1'b0;
                    end
                end else begin
                    // Dropping en only marks the stop; re-raising it before the wrap cancels.
                    state_d = en_i ? StRun : StStopping;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            d_act_q  <= CW'(DEF_DIV);
            d_pend_q <= CW'(DEF_DIV);
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_act_q  <= d_act_d;
            d_pend_q <= d_pend_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
        end
    end

`ifdef DUTY50_EN
    // Half-cycle delayed copy stretches the high phase by half a clk for odd divisors.
    logic neg_q;

    always_ff @(negedge clk or posedge w_rst) begin
        if (w_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= out_q;
        end
    end

    assign clk_out_o = out_q | (d_act_q[0] & neg_q);
`else
    assign clk_out_o = out_q;
`endif

    assign tick_o     = tick_q;
    assign load_ack_o = ack_q;
    assign run_o      = (state_q != StIdle);

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers.
//   Channel i uses div_val[i*CW +: CW] and bit i of every per-channel vector.
// Build option: DUTY50_EN (see clk_div_chan) selects 50% duty for odd divisors.
// Ports:
//   clk       source clock
//   w_rst     asynchronous active-high reset, all channels
//   div_en    per-channel run request (level)
//   div_val   per-channel new divisor, CW bits each
//   div_load  per-channel one-cycle load strobe
//   load_ack  per-channel pulse when the pending divisor becomes active
//   clk_out   per-channel divided clock
//   tick      per-channel pulse at the start of each output period
//   run       per-channel running status
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic              clk,
    input  logic              w_rst,
    input  logic [NCH-1:0]    div_en,
    input  logic [NCH*CW-1:0] div_val,
    input  logic [NCH-1:0]    div_load,
    output logic [NCH-1:0]    load_ack,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    run
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk        (clk),
            .w_rst      (w_rst),
            .en_i       (div_en[i]),
            .div_val_i  (div_val[i*CW +: CW]),
            .div_load_i (div_load[i]),
            .load_ack_o (load_ack[i]),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i]),
            .run_o      (run[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: self-checking bench for clk_div_multi (NCH=2, CW=8, DEF_DIV=2).
//   A behavioural reference steps once per clk, pushing the expected outputs onto a
//   scoreboard queue; each test pops and compares after the edge, plus explicit
//   period/ack/tick counts derived by hand.
module tb_clk_div_multi;

    localparam int unsigned NCH     = 2;
    localparam int unsigned CW      = 8;
    localparam int unsigned DEF_DIV = 2;
`ifdef DUTY50_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              w_rst = 1'b1;
    logic [NCH-1:0]    div_en = '0;
    logic [NCH*CW-1:0] div_val = '0;
    logic [NCH-1:0]    div_load = '0;
    logic [NCH-1:0]    load_ack;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    run;

    clk_div_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .w_rst    (w_rst),
        .div_en   (div_en),
        .div_val  (div_val),
        .div_load (div_load),
        .load_ack (load_ack),
        .clk_out  (clk_out),
        .tick     (tick),
        .run      (run)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] ack;
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] rn;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    bit          m_run[NCH];
    int unsigned m_cnt[NCH];
    int unsigned m_dact[NCH];
    int unsigned m_dpend[NCH];
    bit          m_pv[NCH];
    bit          m_co[NCH];
    bit          m_tk[NCH];

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_cnt[i] = 0; m_dact[i] = DEF_DIV; m_dpend[i] = DEF_DIV;
            m_pv[i] = 0; m_co[i] = 0; m_tk[i] = 0;
        end
        sb_q.delete();
    endtask

    // Step the reference with the inputs currently driven, push the expectation,
    // then advance to 1 time unit after the next rising edge.
    task automatic cycle();
        obs_t e;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            int unsigned cnt = m_cnt[i];
            int unsigned d = m_dact[i];
            int unsigned v = 32'(div_val[i*CW +: CW]);
            bit wrap = m_run[i] && (cnt == d - 1);
            bit apply = m_pv[i] && (!m_run[i] || wrap);
            bit prev_co = m_co[i];
            if (!m_run[i]) begin
                m_co[i] = 0;
                m_tk[i] = 0;
                if (div_en[i]) begin
                    m_run[i] = 1;
                    m_cnt[i] = 0;
                end
            end else begin
                m_co[i] = (cnt < d / 2);
                m_tk[i] = (cnt == 0);
                m_cnt[i] = wrap ? 0 : cnt + 1;
                if (wrap && !div_en[i]) begin
                    m_run[i] = 0;
                    m_co[i] = 0;
                end
            end
            if (apply) begin
                m_dact[i] = m_dpend[i];
                m_pv[i] = 0;
            end
            if (div_load[i]) begin
                m_dpend[i] = (v < 2) ? 2 : v;
                m_pv[i] = 1;
            end
            e.ack[i] = apply;
            e.tk[i] = m_tk[i];
            e.rn[i] = m_run[i];
            e.co[i] = m_co[i] | (DUTY && (m_dact[i] % 2 == 1) && prev_co);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int ch, input int unsigned v);
        div_val[ch*CW +: CW] = CW'(v);
    endtask

    task automatic test_reset();
        obs_t e, o;
        #12;
        checks++;
        if ({load_ack, clk_out, tick, run} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {load_ack, clk_out, tick, run});
        end
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        model_reset();
        for (int j = 0; j < 4; j++) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", j, o, e);
            end
        end
    endtask

    task automatic test_default_div();
        obs_t e, o;
        int ticks = 0;
        div_en[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL default_div cyc%0d: got %h want %h", j, o, e);
            end
            if (j == 0) begin
                checks++;
                if (run[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL start_run: got %b want 1", run[0]);
                end
            end
            ticks += int'(tick[0]);
        end
        checks++;
        if (ticks != 4) begin
            failures++;
            $display("FAIL default_ticks: got %0d want 4", ticks);
        end
    endtask

    task automatic test_load();
        obs_t e, o;
        int acks = 0;
        int highs = 0;
        div_en[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            div_load[1] = (j == 3);
            set_val(1, (j == 3) ? 3 : 9);
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL load_d3 cyc%0d: got %h want %h", j, o, e);
            end
            acks += int'(load_ack[1]);
            if (j >= 10) highs += int'(clk_out[1]);
        end
        div_load = '0;
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL load_ack_count: got %0d want 1", acks);
        end
        checks++;
        if (highs != (DUTY ? 4 : 2)) begin
            failures++;
            $display("FAIL load_d3_high: got %0d want %0d", highs, DUTY ? 4 : 2);
        end
    endtask

    task automatic test_clamp();
        obs_t e, o;
        int ticks;
        int unsigned vals[3] = '{5, 0, 1};
        for (int k = 0; k < 3; k++) begin
            ticks = 0;
            for (int j = 0; j < 12; j++) begin
                div_load[0] = (j == 0);
                set_val(0, vals[k]);
                cycle();
                e = sb_q.pop_front();
                o = {load_ack, clk_out, tick, run};
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL clamp_val%0d cyc%0d: got %h want %h", vals[k], j, o, e);
                end
                if (j >= 8) ticks += int'(tick[0]);
            end
            div_load = '0;
            if (k > 0) begin
                checks++;
                if (ticks != 2) begin
                    failures++;
                    $display("FAIL clamp_period val%0d: got %0d ticks want 2", vals[k], ticks);
                end
            end
        end
    endtask

    task automatic test_stop();
        obs_t e, o;
        int edges = 0;
        int highs = 0;
        int guard = 0;
        for (int j = 0; j < 10; j++) begin
            div_load[1] = (j == 0);
            set_val(1, 6);
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_setup cyc%0d: got %h want %h", j, o, e);
            end
        end
        div_load = '0;
        while (m_cnt[1] != 2 && guard < 12) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_align: got %h want %h", o, e);
            end
            guard++;
        end
        div_en[1] = 1'b0;
        while (run[1] === 1'b1 && edges < 12) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_drain e%0d: got %h want %h", edges, o, e);
            end
            edges++;
            highs += int'(clk_out[1]);
        end
        checks++;
        if (edges != 4) begin
            failures++;
            $display("FAIL stop_edges: got %0d want 4", edges);
        end
        checks++;
        if (highs != 1) begin
            failures++;
            $display("FAIL stop_high_tail: got %0d want 1", highs);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        int acks0 = 0;
        int acks1 = 0;
        int guard = 0;
        for (int j = 0; j < 12; j++) begin
            div_load[0] = (j == 0);
            set_val(0, 8);
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_setup cyc%0d: got %h want %h", j, o, e);
            end
        end
        div_load = '0;
        while (m_cnt[0] != 2 && guard < 16) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_align: got %h want %h", o, e);
            end
            guard++;
        end
        for (int j = 0; j < 24; j++) begin
            div_load[0] = (j < 2);
            set_val(0, (j == 0) ? 4 : 7);
            div_load[1] = (j == 0);
            set_val(1, 9);
            if (j == 0) div_en[1] = 1'b1;
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b cyc%0d: got %h want %h", j, o, e);
            end
            acks0 += int'(load_ack[0]);
            acks1 += int'(load_ack[1]);
        end
        div_load = '0;
        checks++;
        if (acks0 != 1 || acks1 != 1) begin
            failures++;
            $display("FAIL b2b_acks: got ch0=%0d ch1=%0d want 1/1", acks0, acks1);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        int acks = 0;
        int ticks = 0;
        int guard = 0;
        while (m_cnt[0] != 1 && guard < 16) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstmid_align: got %h want %h", o, e);
            end
            guard++;
        end
        div_load[0] = 1'b1;
        set_val(0, 5);
        cycle();
        div_load = '0;
        e = sb_q.pop_front();
        o = {load_ack, clk_out, tick, run};
        checks++;
        if (o !== e || clk_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_high: got %h want %h", o, e);
        end
        #2;
        w_rst = 1'b1;
        #1;
        checks++;
        if ({load_ack, clk_out, tick, run} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got %h want 0", {load_ack, clk_out, tick, run});
        end
        div_en = '0;
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        model_reset();
        div_en[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cycle();
            e = sb_q.pop_front();
            o = {load_ack, clk_out, tick, run};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstmid_restart cyc%0d: got %h want %h", j, o, e);
            end
            acks += int'(load_ack[0]);
            ticks += int'(tick[0]);
        end
        checks++;
        if (acks != 0 || ticks != 4) begin
            failures++;
            $display("FAIL rstmid_discard: got acks=%0d ticks=%0d want 0/4", acks, ticks);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_div();
        test_load();
        test_clamp();
        test_stop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
